// File: rtl/object_spawner_if.sv
// Bundle between the object spawner and its environment: run/random/clear in,
// per-slot positions, visibility and spawn pulses out.
interface object_spawner_if #(
  parameter int NUM_OBJ = 4,
  parameter int POS_W   = 11
);
  logic                       enable;
  logic [31:0]                random_number;
  logic [NUM_OBJ-1:0]         clear;
  logic [NUM_OBJ*POS_W-1:0]   object_position;
  logic [NUM_OBJ-1:0]         object_valid;
  logic [NUM_OBJ-1:0]         spawn_pulse;

  modport master (
    output enable, random_number, clear,
    input  object_position, object_valid, spawn_pulse
  );

  modport slave (
    input  enable, random_number, clear,
    output object_position, object_valid, spawn_pulse
  );
endinterface

// File: rtl/object_spawner.sv
// NUM_OBJ independent object slots: each waits a random delay, shows at a random
// position for LIFETIME cycles (or until cleared), then rearms via a round-robin grant.
module object_spawner #(
  parameter int NUM_OBJ            = 4,
  parameter int POS_W              = 11,
  parameter int DELAY_W            = 16,
  parameter int MIN_DELAY          = 2,
  parameter int LIFETIME           = 600,
  parameter int FIELD_WIDTH        = 800,
  parameter int UNDEFINED_POSITION = 1000
) (
  input logic             clk,
  input logic             rst,
  object_spawner_if.slave bus
);
  localparam int PTR_W  = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;
  localparam int LIFE_W = (LIFETIME > 1) ? $clog2(LIFETIME) : 1;
  localparam logic [POS_W-1:0]  UNDEF_POS = POS_W'(UNDEFINED_POSITION);
  localparam logic [LIFE_W-1:0] LIFE_LOAD = LIFE_W'(LIFETIME - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACTIVE} slot_state_t;

  slot_state_t              state    [NUM_OBJ];
  logic [DELAY_W:0]         wait_cnt [NUM_OBJ];
  logic [LIFE_W-1:0]        life_cnt [NUM_OBJ];
  logic [POS_W-1:0]         pos_q    [NUM_OBJ];
  logic [PTR_W-1:0]         rr_ptr;
  logic [NUM_OBJ-1:0]       valid_q;
  logic [NUM_OBJ-1:0]       spawn_q;
  logic [NUM_OBJ*POS_W-1:0] position_q;

  logic [NUM_OBJ-1:0]       idle;
  logic                     grant_valid;
  int                       grant_idx;
  int                       scan_idx;
  logic [DELAY_W:0]         grant_delay;
  logic [POS_W-1:0]         grant_pos;
  logic                     unused_rand;

  // Two-step fold keeps positions inside the field without a divider.
  function automatic logic [POS_W-1:0] fold_pos(input logic [POS_W-1:0] raw);
    logic [POS_W:0] raw_x;
    logic [POS_W:0] fw;
    logic [POS_W:0] diff;
    raw_x = {1'b0, raw};
    fw    = (POS_W+1)'(FIELD_WIDTH);
    diff  = raw_x - fw;
    if (raw_x < fw)
      fold_pos = raw;
    else if (diff < fw)
      fold_pos = diff[POS_W-1:0];
    else
      fold_pos = POS_W'(FIELD_WIDTH - 1);
  endfunction

  assign grant_delay = {1'b0, bus.random_number[31 -: DELAY_W]} + (DELAY_W+1)'(MIN_DELAY);
  assign grant_pos   = fold_pos(bus.random_number[POS_W-1:0]);
  assign unused_rand = ^bus.random_number;

  always_comb begin
    idle = '0;
    for (int i = 0; i < NUM_OBJ; i++)
      idle[i] = (state[i] == S_IDLE);
  end

  // Round-robin search starting at rr_ptr; first IDLE slot found wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = 0;
    scan_idx    = 0;
    for (int k = 0; k < NUM_OBJ; k++) begin
      scan_idx = (int'(rr_ptr) + k) % NUM_OBJ;
      if (!grant_valid && idle[scan_idx]) begin
        grant_valid = 1'b1;
        grant_idx   = scan_idx;
      end
    end
    if (!bus.enable)
      grant_valid = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr     <= '0;
      valid_q    <= '0;
      spawn_q    <= '0;
      position_q <= {NUM_OBJ{UNDEF_POS}};
      for (int i = 0; i < NUM_OBJ; i++) begin
        state[i]    <= S_IDLE;
        wait_cnt[i] <= '0;
        life_cnt[i] <= '0;
        pos_q[i]    <= '0;
      end
    end else if (bus.enable) begin
      spawn_q <= '0;
      if (grant_valid)
        rr_ptr <= PTR_W'((grant_idx + 1) % NUM_OBJ);
      for (int i = 0; i < NUM_OBJ; i++) begin
        case (state[i])
          S_IDLE: begin
            if (grant_valid && grant_idx == i) begin
              pos_q[i]    <= grant_pos;
              wait_cnt[i] <= grant_delay;
              state[i]    <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (bus.clear[i]) begin
              state[i] <= S_IDLE;
            end else if (wait_cnt[i] != '0) begin
              wait_cnt[i] <= wait_cnt[i] - (DELAY_W+1)'(1);
            end else begin
              state[i]                      <= S_ACTIVE;
              life_cnt[i]                   <= LIFE_LOAD;
              valid_q[i]                    <= 1'b1;
              spawn_q[i]                    <= 1'b1;
              position_q[i*POS_W +: POS_W]  <= pos_q[i];
            end
          end
          S_ACTIVE: begin
            if (bus.clear[i] || life_cnt[i] == '0) begin
              state[i]                      <= S_IDLE;
              valid_q[i]                    <= 1'b0;
              position_q[i*POS_W +: POS_W]  <= UNDEF_POS;
            end else begin
              life_cnt[i] <= life_cnt[i] - LIFE_W'(1);
            end
          end
          default: state[i] <= S_IDLE;
        endcase
      end
    end else begin
      spawn_q <= '0;
    end
  end

  assign bus.object_position = position_q;
  assign bus.object_valid    = valid_q;
  assign bus.spawn_pulse     = spawn_q;
endmodule

// File: tb/tb_object_spawner.sv
// Directed bench for object_spawner: a 1-slot and a 4-slot instance share clock and reset.
module tb_object_spawner;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   edge_n = -3;

  always #5 clk = ~clk;

  object_spawner_if #(.NUM_OBJ(1), .POS_W(11)) bus1 ();
  object_spawner_if #(.NUM_OBJ(4), .POS_W(11)) bus4 ();

  object_spawner #(.NUM_OBJ(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  object_spawner #(.NUM_OBJ(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

  typedef struct {
    logic [31:0] rnd;
    logic [10:0] pos;
    int          wait_edges;
  } fold_vec_t;

  fold_vec_t vecs [8];

  task automatic applyStimulus(input logic en1, input logic en4, input logic [31:0] rnd,
                               input logic clr1, input logic [3:0] clr4);
    bus1.enable        = en1;
    bus4.enable        = en4;
    bus1.random_number = rnd;
    bus4.random_number = rnd;
    bus1.clear         = clr1;
    bus4.clear         = clr4;
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at edge %0d: got %0h, expected %0h", name, edge_n, actual, expected);
    end
  endtask

  function automatic logic [10:0] field4(input int i);
    return bus4.object_position[i*11 +: 11];
  endfunction

  initial begin
    logic       en4;
    logic [31:0] rnd;
    logic [3:0] clr4;
    int         cnt;

    vecs[0] = '{32'h0003_0064, 11'd100, 6};
    vecs[1] = '{32'h0000_07FF, 11'd799, 3};
    vecs[2] = '{32'h0001_0384, 11'd100, 4};
    vecs[3] = '{32'h0000_031F, 11'd799, 3};
    vecs[4] = '{32'h0000_0320, 11'd0,   3};
    vecs[5] = '{32'h0000_F805, 11'd5,   3};
    vecs[6] = '{32'h000A_04B0, 11'd400, 13};
    vecs[7] = '{32'h0000_0000, 11'd0,   3};

    // Reset held for three edges with random activity on every input.
    rst = 1'b1;
    for (int i = 0; i < 3; i++)
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
                    1'($urandom_range(0, 1)), 4'($urandom));
    checkOutput("rst_pos4",   64'(bus4.object_position), 64'({4{11'd1000}}));
    checkOutput("rst_valid4", 64'(bus4.object_valid), 64'd0);
    checkOutput("rst_spawn4", 64'(bus4.spawn_pulse), 64'd0);
    checkOutput("rst_pos1",   64'(bus1.object_position), 64'd1000);
    checkOutput("rst_valid1", 64'(bus1.object_valid), 64'd0);
    checkOutput("rst_spawn1", 64'(bus1.spawn_pulse), 64'd0);
    rst = 1'b0;

    // Main timeline: single-slot lifetime, round-robin, early clear, freeze.
    for (int e = 1; e <= 617; e++) begin
      en4  = !(e >= 25 && e <= 34);
      rnd  = 32'h0003_0064;
      clr4 = 4'b0000;
      case (e)
        12: clr4 = 4'b0100;
        13: rnd  = 32'h0000_0320;
        17: clr4 = 4'b1000;
        18: rnd  = 32'h0014_0064;
        24: clr4 = 4'b0010;
        default: ;
      endcase
      if (!en4) begin
        rnd  = 32'h0000_0000;
        clr4 = 4'b0001;
      end
      applyStimulus(1'b1, en4, rnd, 1'b0, clr4);
      case (e)
        6: begin
          checkOutput("pre_valid1", 64'(bus1.object_valid), 64'd0);
          checkOutput("pre_valid4", 64'(bus4.object_valid), 64'd0);
        end
        7: begin
          checkOutput("spawn_valid1", 64'(bus1.object_valid), 64'd1);
          checkOutput("spawn_pos1",   64'(bus1.object_position), 64'd100);
          checkOutput("spawn_pulse1", 64'(bus1.spawn_pulse), 64'd1);
          checkOutput("rr_valid4_e7", 64'(bus4.object_valid), 64'b0001);
          checkOutput("rr_spawn4_e7", 64'(bus4.spawn_pulse), 64'b0001);
        end
        8: begin
          checkOutput("pulse_end1",   64'(bus1.spawn_pulse), 64'd0);
          checkOutput("rr_valid4_e8", 64'(bus4.object_valid), 64'b0011);
          checkOutput("rr_spawn4_e8", 64'(bus4.spawn_pulse), 64'b0010);
        end
        9: begin
          checkOutput("rr_valid4_e9", 64'(bus4.object_valid), 64'b0111);
          checkOutput("rr_spawn4_e9", 64'(bus4.spawn_pulse), 64'b0100);
        end
        10: begin
          checkOutput("rr_valid4_e10", 64'(bus4.object_valid), 64'b1111);
          checkOutput("rr_spawn4_e10", 64'(bus4.spawn_pulse), 64'b1000);
          checkOutput("rr_pos4",       64'(bus4.object_position), 64'({4{11'd100}}));
        end
        12: begin
          checkOutput("clr_valid4", 64'(bus4.object_valid), 64'b1011);
          checkOutput("clr_pos2",   64'(field4(2)), 64'd1000);
        end
        15: checkOutput("rearm_wait_valid4", 64'(bus4.object_valid), 64'b1011);
        16: begin
          checkOutput("rearm_valid4", 64'(bus4.object_valid), 64'b1111);
          checkOutput("rearm_spawn4", 64'(bus4.spawn_pulse), 64'b0100);
          checkOutput("rearm_pos2",   64'(field4(2)), 64'd0);
        end
        17: checkOutput("clr3_pos3", 64'(field4(3)), 64'd1000);
        24: checkOutput("clr1_valid4", 64'(bus4.object_valid), 64'b0101);
        40: checkOutput("frz_grant_wait_valid4", 64'(bus4.object_valid), 64'b0101);
        41: begin
          checkOutput("frz_grant_valid4", 64'(bus4.object_valid), 64'b0111);
          checkOutput("frz_grant_spawn4", 64'(bus4.spawn_pulse), 64'b0010);
          checkOutput("frz_grant_pos1",   64'(field4(1)), 64'd100);
        end
        50: checkOutput("frz_wait_valid4", 64'(bus4.object_valid), 64'b0111);
        51: begin
          checkOutput("frz_wait_valid4_on", 64'(bus4.object_valid), 64'b1111);
          checkOutput("frz_wait_spawn4",    64'(bus4.spawn_pulse), 64'b1000);
          checkOutput("frz_wait_pos3",      64'(field4(3)), 64'd100);
        end
        606: checkOutput("life_last_valid1", 64'(bus1.object_valid), 64'd1);
        607: begin
          checkOutput("life_end_valid1", 64'(bus1.object_valid), 64'd0);
          checkOutput("life_end_pos1",   64'(bus1.object_position), 64'd1000);
        end
        616: checkOutput("frz_life_last_valid4", 64'(bus4.object_valid), 64'b1111);
        617: begin
          checkOutput("frz_life_end_valid4", 64'(bus4.object_valid), 64'b1110);
          checkOutput("frz_life_end_pos0",   64'(field4(0)), 64'd1000);
        end
        default: ;
      endcase
      if (!en4) begin
        checkOutput("frz_spawn4", 64'(bus4.spawn_pulse), 64'd0);
        checkOutput("frz_valid4", 64'(bus4.object_valid), 64'b0101);
      end
    end

    // Reset while objects are visible in both instances.
    rst = 1'b1;
    applyStimulus(1'b1, 1'b1, 32'h0003_0064, 1'b0, 4'b0000);
    checkOutput("midrst_valid4", 64'(bus4.object_valid), 64'd0);
    checkOutput("midrst_pos4",   64'(bus4.object_position), 64'({4{11'd1000}}));
    checkOutput("midrst_spawn4", 64'(bus4.spawn_pulse), 64'd0);
    checkOutput("midrst_valid1", 64'(bus1.object_valid), 64'd0);
    checkOutput("midrst_pos1",   64'(bus1.object_position), 64'd1000);
    rst = 1'b0;

    // Position fold and delay table on the single-slot instance.
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b1, 1'b0, vecs[k].rnd, 1'b0, 4'b0000);
      cnt = 0;
      do begin
        applyStimulus(1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0, 4'b0000);
        cnt++;
      end while (!bus1.object_valid[0] && cnt < 40);
      checkOutput($sformatf("vec%0d_wait", k),  64'(cnt), 64'(vecs[k].wait_edges));
      checkOutput($sformatf("vec%0d_pos", k),   64'(bus1.object_position), 64'(vecs[k].pos));
      checkOutput($sformatf("vec%0d_spawn", k), 64'(bus1.spawn_pulse), 64'd1);
      applyStimulus(1'b1, 1'b0, 32'hDEAD_BEEF, 1'b1, 4'b0000);
      checkOutput($sformatf("vec%0d_clr_valid", k), 64'(bus1.object_valid), 64'd0);
      checkOutput($sformatf("vec%0d_clr_pos", k),   64'(bus1.object_position), 64'd1000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/object_spawner.md
# object_spawner

Parametrised multi-object spawner for the game field. It drives NUM_OBJ independent object slots. Each slot waits a random delay, appears at a random horizontal position for a bounded lifetime, and then respawns. Sits between the shared LFSR random source and the renderer/collision logic; the collision logic can retire an object early through `clear`.

## Interface
- NUM_OBJ, 4, number of object slots (1..16)
- POS_W, 11, position width in bits
- DELAY_W, 16, width of the random delay field (1..31)
- MIN_DELAY, 2, constant added to every random delay; must be < 2^DELAY_W
- LIFETIME, 600, cycles an object stays visible (>= 1)
- FIELD_WIDTH, 800, legal positions are 0..FIELD_WIDTH-1; must be < 2^POS_W
- UNDEFINED_POSITION, 1000, position reported by a slot with no visible object
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- enable  in  1  run; low freezes all counters, grants and outputs
- random_number  in  32  shared random word, new value expected every cycle
- clear  in  NUM_OBJ  per-slot early retire (collision/hit)
- object_position  out  NUM_OBJ*POS_W  slot i at bits [i*POS_W +: POS_W]
- object_valid  out  NUM_OBJ  slot i currently visible
- spawn_pulse  out  NUM_OBJ  one-cycle pulse on the first visible cycle of slot i

## Operation
- Per-slot FSM: IDLE -> WAIT -> ACTIVE -> IDLE.
- Arm arbiter: at most one IDLE slot is granted per cycle, chosen round-robin. The search starts at `rr_ptr`. After a grant, `rr_ptr` becomes (granted index + 1) mod NUM_OBJ. With no grant, `rr_ptr` holds.
- A grant requires enable=1. It samples random_number once per grant:
  - delay D = MIN_DELAY + random_number[31 -: DELAY_W]
  - raw = random_number[POS_W-1:0]
  - pos = raw if raw < FIELD_WIDTH; else raw-FIELD_WIDTH if that is < FIELD_WIDTH; else FIELD_WIDTH-1
- On grant, the slot stores pos, loads its wait counter (DELAY_W+1 bits) with D, and enters WAIT.
- WAIT:
  - If the counter is nonzero, it decrements by 1 each enabled cycle.
  - If the counter is zero on an enabled edge, the slot enters ACTIVE and loads its life counter with LIFETIME-1.
- ACTIVE: object_valid=1 and the stored pos is output.
  - The life counter decrements each enabled cycle.
  - When the counter is zero on an enabled edge, the slot returns to IDLE.
- clear[i] on an enabled edge forces slot i to IDLE from WAIT or ACTIVE. It has priority over every other transition of that slot. It is ignored in IDLE.
- A slot not in ACTIVE outputs UNDEFINED_POSITION with object_valid=0.
- enable=0: no grants, counters and states hold, and clear is ignored. spawn_pulse is forced to 0, and all other outputs hold.

## Timing
- Reset (sampled at the clk edge) has priority over everything:
  - all slots go to IDLE and rr_ptr=0
  - object_valid=0 and spawn_pulse=0
  - every object_position field = UNDEFINED_POSITION
- All outputs are registered. object_valid, position and spawn_pulse change on the same edge that enters ACTIVE.
- A slot granted at edge g spends D+1 enabled cycles in WAIT and is visible from edge g+D+1. It stays visible for exactly LIFETIME enabled cycles and is IDLE from edge g+D+1+LIFETIME.
- A slot returning to IDLE at edge t is eligible for a grant at edge t+1, never at edge t.
- rst asserted mid-operation discards all pending delays and visible objects within one edge.
- Width rule: D is computed at DELAY_W+1 bits with no overflow, because MIN_DELAY < 2^DELAY_W.

## Test plan
- Reset values: hold rst for 3 cycles with random activity, then release -> every position field = 1000, object_valid=0, spawn_pulse=0.
- Single-slot spawn:
  - Setup: NUM_OBJ=1, random_number held at 0x0003_0064, enable=1, rst released at edge 0.
  - Expected: grant at edge 1 (D=5); valid=1, position=100 and spawn_pulse=1 after edge 7; valid drops after edge 607.
- Round-robin arming: NUM_OBJ=4 with constant random -> slots 0, 1, 2, 3 granted on consecutive edges 1..4 and become visible on edges 7..10 in order.
- Position fold at FIELD_WIDTH=800:
  - raw 0x7FF -> 799
  - raw 900 -> 100
  - raw 799 -> 799
  - raw 800 -> 0
- Early clear and rearm: pulse clear[2] on the third visible cycle of slot 2 -> valid[2]=0 and position=1000 on the next edge. Slot 2 is re-granted on the following edge when it is the only IDLE slot.
- Freeze:
  - Drop enable for 10 cycles in mid-WAIT and in mid-ACTIVE -> appearance and expiry both shift by exactly 10 cycles, with no grants and no spawn_pulse during the freeze.
  - Assert rst during ACTIVE -> all slots go to the reset values on the next edge.
